// File: rtl/adc_pkg.sv
// adc_pkg: shared frame constants and FSM state encoding for the ADC serial controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package adc_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int ADDR_FIRST_BIT = 2;
  localparam int DATA_FIRST_BIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/adc_if.sv
// adc_if: request/result handshake plus the four ADC serial pins, bundled for the controller.
// Latency: n/a (wiring only).
// Backpressure: requester watches busy; start is only honoured while the controller is idle.
interface adc_if #(
  parameter int DATA_W = 12,
  parameter int CH_W   = 3
);

  logic              start;
  logic [CH_W-1:0]   channel;
  logic              busy;
  logic              adc_cs_n;
  logic              adc_sck;
  logic              adc_din;
  logic              adc_dout;
  logic [DATA_W-1:0] data_out;
  logic [CH_W-1:0]   data_channel;
  logic              data_valid;

  modport master (
    input  start, channel, adc_dout,
    output busy, adc_cs_n, adc_sck, adc_din, data_out, data_channel, data_valid
  );

  modport slave (
    output start, channel, adc_dout,
    input  busy, adc_cs_n, adc_sck, adc_din, data_out, data_channel, data_valid
  );

endinterface

// File: rtl/adc_controller.sv
// adc_controller: runs one 16-bit ADC128S022-style serial frame per accepted start, returns 12-bit result.
// Latency: 33 cycles from the start-accept edge to the data_valid strobe; 34-cycle minimum start period.
// Backpressure: start is sampled only while idle; busy stays high for the whole frame.
module adc_controller
  import adc_pkg::state_t;
  import adc_pkg::IDLE;
  import adc_pkg::SETUP;
  import adc_pkg::SHIFT;
  import adc_pkg::ADDR_FIRST_BIT;
  import adc_pkg::DATA_FIRST_BIT;
#(
  parameter int DATA_W     = 12,
  parameter int CH_W       = 3,
  parameter int FRAME_BITS = 16
) (
  input  logic  clk_3125KHz,
  input  logic  reset,
  adc_if.master bus
);

  localparam int                CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  DATA_FIRST = CNT_W'(DATA_FIRST_BIT);
  localparam int                ADDR_SHIFT = FRAME_BITS - ADDR_FIRST_BIT - CH_W;
  // phase_q names the sck edge the next shift cycle will produce
  localparam logic              PH_LOW     = 1'b0;
  localparam logic              PH_HIGH    = 1'b1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                phase_q, phase_d;
  logic                last_q, last_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                cs_n_q, cs_n_d;
  logic                sck_q, sck_d;
  logic                din_q, din_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [CH_W-1:0]     data_ch_q, data_ch_d;
  logic                valid_q, valid_d;
  logic [FRAME_BITS-1:0] addr_word;

  // Whole-frame address pattern, MSB first: bit k of the frame is addr_word[LAST_BIT - k].
  assign addr_word = FRAME_BITS'(ch_q) << ADDR_SHIFT;

  // Next-state and registered-output logic; SETUP's exit edge is already the falling edge of bit 0.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    last_d     = last_q;
    ch_d       = ch_q;
    sh_d       = sh_q;
    cs_n_d     = cs_n_q;
    sck_d      = sck_q;
    din_d      = din_q;
    busy_d     = busy_q;
    data_out_d = data_out_q;
    data_ch_d  = data_ch_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          ch_d    = bus.channel;
          bit_d   = '0;
          phase_d = PH_LOW;
          last_d  = 1'b0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETUP, SHIFT: begin
        state_d = SHIFT;
        if (last_q) begin
          // Edge after the final rising edge: close the frame and publish the result.
          state_d    = IDLE;
          last_d     = 1'b0;
          cs_n_d     = 1'b1;
          sck_d      = 1'b1;
          din_d      = 1'b0;
          busy_d     = 1'b0;
          data_out_d = sh_q;
          data_ch_d  = ch_q;
          valid_d    = 1'b1;
        end else if (phase_q == PH_LOW) begin
          sck_d   = 1'b0;
          din_d   = addr_word[LAST_BIT - bit_q];
          phase_d = PH_HIGH;
        end else begin
          sck_d   = 1'b1;
          phase_d = PH_LOW;
          // Leading zero bits from the ADC are dropped; only the 12 data bits enter the shifter.
          if (bit_q >= DATA_FIRST) begin
            sh_d = {sh_q[DATA_W-2:0], bus.adc_dout};
          end
          if (bit_q == LAST_BIT) begin
            last_d = 1'b1;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      phase_q    <= PH_LOW;
      last_q     <= 1'b0;
      ch_q       <= '0;
      sh_q       <= '0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b1;
      din_q      <= 1'b0;
      busy_q     <= 1'b0;
      data_out_q <= '0;
      data_ch_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      last_q     <= last_d;
      ch_q       <= ch_d;
      sh_q       <= sh_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
      data_ch_q  <= data_ch_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.adc_cs_n     = cs_n_q;
  assign bus.adc_sck      = sck_q;
  assign bus.adc_din      = din_q;
  assign bus.data_out     = data_out_q;
  assign bus.data_channel = data_ch_q;
  assign bus.data_valid   = valid_q;

endmodule

// File: tb/tb_adc_controller.sv
// tb_adc_controller: randomized and directed frames against a frame-level model and an ADC pin model.
// Latency: expects data_valid 33 cycles after each accepted start, starts honoured every 34 cycles.
// Backpressure: model ignores start while a frame is in flight, mirroring the busy window.
module tb_adc_controller;

  typedef struct {
    logic [11:0] data;
    logic [2:0]  ch;
    logic [15:0] din;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  adc_if #(.DATA_W(12), .CH_W(3)) bus ();

  adc_controller #(.DATA_W(12), .CH_W(3), .FRAME_BITS(16)) dut (
    .clk_3125KHz (clk),
    .reset       (rst),
    .bus         (bus)
  );

  always #160 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          next_free = 0;
  int          nvalid = 0;
  int          fall_cnt = 0;
  int          nv0;
  bit          act = 1'b0;
  bit          exp_busy;
  logic        sck_prev = 1'b1;
  logic [15:0] din_seen = '0;
  logic [15:0] next_word = '0;
  logic [15:0] cur_word = '0;
  exp_t        exp_q[$];
  exp_t        ne;
  exp_t        ce;
  int          vcyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Address bits the ADC must see on din: channel MSB first at frame bits 2,3,4, zero elsewhere.
  function automatic logic [15:0] addr_pattern(input logic [2:0] ch);
    logic [15:0] p;
    p    = '0;
    p[2] = ch[2];
    p[3] = ch[1];
    p[4] = ch[0];
    return p;
  endfunction

  // Frame-level model: a start is accepted when no frame is in flight.
  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.start && cyc >= next_free) begin
      ne.data   = next_word[11:0];
      ne.ch     = bus.channel;
      ne.din    = addr_pattern(bus.channel);
      ne.due    = cyc + 33;
      exp_q.push_back(ne);
      cur_word  = next_word;
      next_word = 16'($urandom);
      acc_cyc   = cyc;
      act       = 1'b1;
      next_free = cyc + 34;
    end
  end

  // Output checks plus the ADC pin model (DOUT advances on each SCLK falling edge).
  always @(negedge clk) begin
    if (!rst) begin
      exp_busy = act && ((cyc - acc_cyc) < 33);
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("cs_n", 32'(bus.adc_cs_n), 32'(!exp_busy));
      if (bus.data_valid) begin
        nvalid++;
        vcyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(bus.data_valid), 0);
        end else begin
          ce = exp_q.pop_front();
          chk("latency", cyc, ce.due);
          chk("data_out", 32'(bus.data_out), 32'(ce.data));
          chk("data_channel", 32'(bus.data_channel), 32'(ce.ch));
          chk("din_addr", 32'(din_seen), 32'(ce.din));
          chk("sclk_count", fall_cnt, 16);
        end
      end else if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
        chk("missing_valid", 32'(bus.data_valid), 1);
        void'(exp_q.pop_front());
      end
    end
    if (bus.adc_cs_n) begin
      fall_cnt = 0;
      din_seen = '0;
    end else if (sck_prev && !bus.adc_sck) begin
      if (fall_cnt < 16) begin
        bus.adc_dout       = cur_word[15 - fall_cnt];
        din_seen[fall_cnt] = bus.adc_din;
      end
      fall_cnt++;
    end
    sck_prev = bus.adc_sck;
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_cs_n"}, 32'(bus.adc_cs_n), 1);
    chk({tag, "_sck"}, 32'(bus.adc_sck), 1);
    chk({tag, "_din"}, 32'(bus.adc_din), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_valid"}, 32'(bus.data_valid), 0);
    chk({tag, "_data_out"}, 32'(bus.data_out), 0);
    chk({tag, "_data_ch"}, 32'(bus.data_channel), 0);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    act = 1'b0;
    next_free = 0;
    exp_q.delete();
    #1;
    check_reset_values(tag);
    @(posedge clk); #5;
    rst = 1'b0;
  endtask

  task automatic launch(input logic [2:0] ch, input logic [15:0] word);
    @(posedge clk); #5;
    next_word   = word;
    bus.channel = ch;
    bus.start   = 1'b1;
    @(posedge clk); #5;
    bus.start   = 1'b0;
  endtask

  task automatic wait_done();
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && !bus.busy;
    end
    if (!done) chk("wait_timeout", 32'(done), 1);
    @(posedge clk); #5;
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.channel  = '0;
    bus.adc_dout = 1'b0;
    repeat (2) @(posedge clk);
    #5;
    check_reset_values("por");
    rst = 1'b0;

    // Reset in the middle of a frame (bit 8 falling edge), then a clean conversion.
    launch(3'd7, 16'h1234);
    repeat (17) @(posedge clk);
    #5;
    reset_pulse("midframe");
    launch(3'd2, 16'hC123);
    wait_done();
    chk("after_reset_data", 32'(bus.data_out), 32'h123);
    chk("after_reset_ch", 32'(bus.data_channel), 2);

    // Single conversion on channel 5.
    launch(3'd5, 16'h3A5C);
    wait_done();
    chk("single_data", 32'(bus.data_out), 32'hA5C);
    chk("single_ch", 32'(bus.data_channel), 5);

    // start re-asserted during SETUP and at bit 10 must be ignored.
    nv0 = nvalid;
    @(posedge clk); #5;
    next_word   = 16'($urandom);
    bus.channel = 3'd1;
    bus.start   = 1'b1;
    @(posedge clk); #5;
    @(posedge clk); #5;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #5;
    bus.start = 1'b1;
    @(posedge clk); #5;
    bus.start = 1'b0;
    wait_done();
    chk("ignore_single_valid", nvalid - nv0, 1);

    // start held high across three frames.
    nv0 = nvalid;
    vcyc.delete();
    @(posedge clk); #5;
    bus.channel = 3'($urandom_range(0, 7));
    bus.start   = 1'b1;
    repeat (69) @(posedge clk);
    #5;
    bus.start = 1'b0;
    wait_done();
    chk("b2b_frames", nvalid - nv0, 3);
    if (vcyc.size() == 3) begin
      chk("b2b_gap0", vcyc[1] - vcyc[0], 34);
      chk("b2b_gap1", vcyc[2] - vcyc[1], 34);
    end

    // Channel changes to 6 at bit 1; the running frame keeps channel 3.
    @(posedge clk); #5;
    next_word   = 16'($urandom);
    bus.channel = 3'd3;
    bus.start   = 1'b1;
    @(posedge clk); #5;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #5;
    bus.channel = 3'd6;
    wait_done();
    chk("chg_data_channel", 32'(bus.data_channel), 3);

    // Data extremes, with nonzero leading bits on the second one.
    launch(3'd4, 16'h0FFF);
    wait_done();
    chk("extreme_fff", 32'(bus.data_out), 32'hFFF);
    launch(3'd1, 16'hF000);
    wait_done();
    chk("extreme_000", 32'(bus.data_out), 32'h000);

    // Randomized conversions with random idle gaps.
    for (int i = 0; i < 8; i++) begin
      launch(3'($urandom_range(0, 7)), 16'($urandom));
      wait_done();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(320 * 20000);
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
